// File: rtl/alu_exec_stage_pkg.sv
// Shared core definitions: ALU control codes, field widths and the EX slot state.
// The decode-side ALU control logic uses the same code constants.
package alu_exec_stage_pkg;

   localparam int unsigned ALU_CTRL_W = 3;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU datapath: control code and operands in, result, zero and illegal flag out.
module alu_core
   import alu_exec_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [ALU_CTRL_W-1:0] code,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic [WIDTH-1:0]      result_c,
   output logic                  zero_c,
   output logic                  illegal_c
);

   logic less_c;

   assign less_c = ($signed(a) < $signed(b));

   // Unrecognised codes produce a zero result and raise illegal.
   always_comb begin
      result_c  = '0;
      illegal_c = 1'b0;
      case (code)
         ALU_ADD: result_c = a + b;
         ALU_SUB: result_c = a - b;
         ALU_AND: result_c = a & b;
         ALU_OR:  result_c = a | b;
         ALU_SLT: result_c = {{(WIDTH-1){1'b0}}, less_c};
         default: illegal_c = 1'b1;
      endcase
   end

   assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a single-entry output slot, valid/ready handshake toward memory,
// flush, sticky illegal-code flag and executed-op counter.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RD_W  = REG_ADDR_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   input  logic [RD_W-1:0]       rd_in,
   input  logic                  reg_write_in,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      alu_result,
   output logic                  zero,
   output logic [RD_W-1:0]       rd_out,
   output logic                  reg_write_out,
   output logic                  illegal_op,
   output logic [CNT_W-1:0]      op_count
);

   slot_state_t     state;
   logic [WIDTH-1:0] result_c;
   logic             zero_c;
   logic             illegal_c;
   logic             accept_c;

   alu_core #(.WIDTH(WIDTH)) u_alu_core (
      .code      (alu_control),
      .a         (src_a),
      .b         (src_b),
      .result_c  (result_c),
      .zero_c    (zero_c),
      .illegal_c (illegal_c)
   );

   // Slot may refill on the same cycle it drains.
   assign in_ready  = (state == SLOT_EMPTY) || out_ready;
   assign accept_c  = in_valid && in_ready && !flush;
   assign out_valid = (state == SLOT_FULL);

   // Flush empties the slot but leaves data, counter and sticky flag untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= SLOT_EMPTY;
         alu_result    <= '0;
         zero          <= 1'b0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
         illegal_op    <= 1'b0;
         op_count      <= '0;
      end else if (flush) begin
         state <= SLOT_EMPTY;
      end else if (accept_c) begin
         state         <= SLOT_FULL;
         alu_result    <= result_c;
         zero          <= zero_c;
         rd_out        <= rd_in;
         reg_write_out <= reg_write_in && !illegal_c;
         illegal_op    <= illegal_op || illegal_c;
         op_count      <= op_count + CNT_W'(1);
      end else if (out_ready) begin
         state <= SLOT_EMPTY;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with hand-computed expected values.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  rd_in;
   logic        reg_write_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_result;
   logic        zero;
   logic [4:0]  rd_out;
   logic        reg_write_out;
   logic        illegal_op;
   logic [15:0] op_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_exec_stage dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_control   (alu_control),
      .src_a         (src_a),
      .src_b         (src_b),
      .rd_in         (rd_in),
      .reg_write_in  (reg_write_in),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .alu_result    (alu_result),
      .zero          (zero),
      .rd_out        (rd_out),
      .reg_write_out (reg_write_out),
      .illegal_op    (illegal_op),
      .op_count      (op_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic rw);
      in_valid     = 1'b1;
      alu_control  = c;
      src_a        = a;
      src_b        = b;
      rd_in        = rd;
      reg_write_in = rw;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      alu_control = 3'b000; src_a = '0; src_b = '0; rd_in = '0; reg_write_in = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      alu_control = 3'b000; src_a = '0; src_b = '0; rd_in = '0; reg_write_in = 1'b0;
      rst = 1'b1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", alu_result); end
      n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
      n_tests++; if (rd_out !== 5'd0 || reg_write_out !== 1'b0) begin n_fail++; $display("FAIL reset_rd_rw: got %h/%b want 0/0", rd_out, reg_write_out); end
      n_tests++; if (illegal_op !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL reset_ill_cnt: got %b/%0d want 0/0", illegal_op, op_count); end
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      do_reset();
      drive_op(3'b000, 32'd7, 32'd5, 5'd3, 1'b1);
      step();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_tests++; if (alu_result !== 32'd12 || zero !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h/%b want c/0", alu_result, zero); end
      n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL add_count: got %0d want 1", op_count); end
      n_tests++; if (rd_out !== 5'd3 || reg_write_out !== 1'b1) begin n_fail++; $display("FAIL add_passthru: got %0d/%b want 3/1", rd_out, reg_write_out); end
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_arith();
      do_reset();
      drive_op(3'b001, 32'd5, 32'd5, 5'd1, 1'b1); step();
      n_tests++; if (alu_result !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL sub_eq: got %h/%b want 0/1", alu_result, zero); end
      drive_op(3'b001, 32'd0, 32'd1, 5'd2, 1'b1); step();
      n_tests++; if (alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin n_fail++; $display("FAIL sub_wrap: got %h/%b want ffffffff/0", alu_result, zero); end
      drive_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1); step();
      n_tests++; if (alu_result !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h want 1", alu_result); end
      drive_op(3'b101, 32'd1, 32'hFFFF_FFFF, 5'd4, 1'b1); step();
      n_tests++; if (alu_result !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL slt_pos: got %h/%b want 0/1", alu_result, zero); end
      drive_op(3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd5, 1'b1); step();
      n_tests++; if (alu_result !== 32'h0F00_0F00) begin n_fail++; $display("FAIL and: got %h want 0f000f00", alu_result); end
      drive_op(3'b011, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd6, 1'b1); step();
      n_tests++; if (alu_result !== 32'hFFF0_FFF0 || rd_out !== 5'd6) begin n_fail++; $display("FAIL or: got %h/%0d want fff0fff0/6", alu_result, rd_out); end
      n_tests++; if (op_count !== 16'd6) begin n_fail++; $display("FAIL arith_count: got %0d want 6", op_count); end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_op(3'b000, 32'd40, 32'd2, 5'd7, 1'b1); step();
      out_ready = 1'b0;
      drive_op(3'b000, 32'd1, 32'd1, 5'd9, 1'b0);
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      step(); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd42 || rd_out !== 5'd7 || reg_write_out !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold: got v=%b r=%h rd=%0d rw=%b want 1/2a/7/1", out_valid, alu_result, rd_out, reg_write_out); end
      n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", op_count); end
      out_ready = 1'b1;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd2 || rd_out !== 5'd9 || op_count !== 16'd2) begin
         n_fail++; $display("FAIL bp_refill: got v=%b r=%h rd=%0d cnt=%0d want 1/2/9/2", out_valid, alu_result, rd_out, op_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_op(3'b000, 32'd10, 32'd20, 5'd1, 1'b1); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd30) begin n_fail++; $display("FAIL b2b_0: got %b/%h want 1/1e", out_valid, alu_result); end
      drive_op(3'b001, 32'd100, 32'd1, 5'd2, 1'b1); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'd99) begin n_fail++; $display("FAIL b2b_1: got %b/%h want 1/63", out_valid, alu_result); end
      drive_op(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 1'b1); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'h0000_F000) begin n_fail++; $display("FAIL b2b_2: got %b/%h want 1/f000", out_valid, alu_result); end
      drive_op(3'b011, 32'h0000_000F, 32'h0000_00F0, 5'd4, 1'b1); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'h0000_00FF || rd_out !== 5'd4) begin n_fail++; $display("FAIL b2b_3: got %b/%h/%0d want 1/ff/4", out_valid, alu_result, rd_out); end
      n_tests++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", op_count); end
      in_valid = 1'b0;
   endtask

   task automatic test_flush_reset();
      do_reset();
      drive_op(3'b000, 32'd10, 32'd20, 5'd4, 1'b1); step();
      out_ready = 1'b0;
      flush = 1'b1;
      drive_op(3'b110, 32'd1, 32'd1, 5'd5, 1'b1);
      step();
      flush = 1'b0; in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      n_tests++; if (op_count !== 16'd1 || illegal_op !== 1'b0) begin n_fail++; $display("FAIL flush_no_update: got cnt=%0d ill=%b want 1/0", op_count, illegal_op); end
      n_tests++; if (alu_result !== 32'd30 || rd_out !== 5'd4) begin n_fail++; $display("FAIL flush_data_hold: got %h/%0d want 1e/4", alu_result, rd_out); end
      out_ready = 1'b1;
      drive_op(3'b000, 32'd1, 32'd2, 5'd6, 1'b1); step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || op_count !== 16'd2) begin n_fail++; $display("FAIL flush_drain: got v=%b cnt=%0d want 0/2", out_valid, op_count); end
      drive_op(3'b000, 32'd5, 32'd5, 5'd8, 1'b1); step();
      #2 rst = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0 || alu_result !== 32'h0 || zero !== 1'b0 || rd_out !== 5'd0 || reg_write_out !== 1'b0 || op_count !== 16'd0 || illegal_op !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: got v=%b r=%h z=%b rd=%0d rw=%b cnt=%0d ill=%b want all 0", out_valid, alu_result, zero, rd_out, reg_write_out, op_count, illegal_op); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b want 1", in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL reset_no_accept: got v=%b cnt=%0d want 0/0", out_valid, op_count); end
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      drive_op(3'b110, 32'd3, 32'd4, 5'd10, 1'b1); step();
      n_tests++; if (out_valid !== 1'b1 || alu_result !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL ill_result: got v=%b r=%h z=%b want 1/0/1", out_valid, alu_result, zero); end
      n_tests++; if (reg_write_out !== 1'b0 || rd_out !== 5'd10) begin n_fail++; $display("FAIL ill_rw: got rw=%b rd=%0d want 0/10", reg_write_out, rd_out); end
      n_tests++; if (illegal_op !== 1'b1 || op_count !== 16'd1) begin n_fail++; $display("FAIL ill_flag: got ill=%b cnt=%0d want 1/1", illegal_op, op_count); end
      drive_op(3'b000, 32'd1, 32'd2, 5'd11, 1'b1); step();
      drive_op(3'b011, 32'd4, 32'd0, 5'd12, 1'b1); step();
      in_valid = 1'b0;
      n_tests++; if (illegal_op !== 1'b1 || alu_result !== 32'd4 || reg_write_out !== 1'b1 || op_count !== 16'd3) begin
         n_fail++; $display("FAIL ill_sticky: got ill=%b r=%h rw=%b cnt=%0d want 1/4/1/3", illegal_op, alu_result, reg_write_out, op_count); end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      drive_op(3'b000, 32'd0, 32'd0, 5'd1, 1'b1);
      repeat (65535) step();
      n_tests++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_max: got %h want ffff", op_count); end
      step();
      in_valid = 1'b0;
      n_tests++; if (op_count !== 16'h0000 || out_valid !== 1'b1) begin n_fail++; $display("FAIL cnt_wrap: got %h/%b want 0000/1", op_count, out_valid); end
      step();
      n_tests++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_idle: got %h want 0000", op_count); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_arith();
      test_backpressure();
      test_back_to_back();
      test_flush_reset();
      test_illegal();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage ALU for the pipelined RISC-V core: consumes the 3-bit ALU control code produced by the decode-side ALU control logic, plus two 32-bit operands. It computes the result and zero flag and registers them into a single-entry EX output slot with a valid/ready handshake toward the memory stage. It supports flush from hazard/branch logic, and tracks illegal control codes with a sticky error flag and an executed-op counter.

## Interface
- `WIDTH`, 32: operand/result width.
- `RD_W`, 5: destination register address width.
- `CNT_W`, 16: executed-op counter width.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: decode stage offers an operation.
- `in_ready` output 1: stage accepts this cycle.
- `alu_control` input 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; 100/110/111 illegal.
- `src_a` input WIDTH: operand A.
- `src_b` input WIDTH: operand B (register or immediate, muxed upstream).
- `rd_in` input RD_W: destination register tag, passed through.
- `reg_write_in` input 1: writeback enable, passed through.
- `flush` input 1: kill held and incoming operation.
- `out_valid` output 1: registered result present.
- `out_ready` input 1: memory stage consumes.
- `alu_result` output WIDTH: registered result.
- `zero` output 1: registered (alu_result == 0).
- `rd_out` output RD_W, `reg_write_out` output 1: registered pass-through.
- `illegal_op` output 1: sticky, set on acceptance of an illegal code.
- `op_count` output CNT_W: count of accepted operations.

## Operation
- Accept = `in_valid && in_ready && !flush`. `in_ready = !out_valid || out_ready` (combinational; the slot may refill on the same cycle it drains).
- Slot states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `out_ready && !accept`.
  - FULL→FULL on hold (`!out_ready`) or on simultaneous drain+accept. In both cases the registers are replaced only on accept.
- `flush` has highest priority. On the next edge `out_valid`=0, no accept occurs, and `op_count` and `illegal_op` do not update. Data registers hold their old values.
- Arithmetic is modulo 2^WIDTH. ADD `a+b`. SUB `a-b`. AND `a&b`. OR `a|b`.
- SLT is a signed compare and gives `{WIDTH-1 zeros, a<b}`. Example: `a`=0xFFFFFFFF, `b`=1 gives 1.
- An illegal code yields `alu_result`=0 and `zero`=1, and sets `illegal_op` on accept. It is still forwarded as a valid op with `reg_write_out` forced to 0.
- `op_count` increments on every accept, including illegal ones, and wraps from 2^CNT_W−1 to 0.
- While FULL and `!out_ready`, all outputs hold stable.

## Timing
- Latency is 1 cycle: an op accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 op/cycle when `out_ready` is held high.
- Reset values: `out_valid`=0, `alu_result`=0, `zero`=0, `rd_out`=0, `reg_write_out`=0, `illegal_op`=0, `op_count`=0.
  - `in_ready`=1 during and after reset, since it is combinational from `out_valid`=0.
- Reset asserted mid-operation discards the held op immediately (asynchronous). No accept occurs while `rst` is high.
- `flush` and `in_valid` in the same cycle: the op is dropped and `in_ready` is ignored.
- `flush` and `out_ready` in the same cycle: the slot empties. The consumer still takes the current output that cycle.

## Structure
- Shared core package holds:
  - the ALU control code constants (`ALU_ADD`=3'b000, `ALU_SUB`=3'b001, `ALU_AND`=3'b010, `ALU_OR`=3'b011, `ALU_SLT`=3'b101);
  - the control code width;
  - the register address width.
  The decode-side ALU control logic uses the same constants.
- One combinational sub-module, `alu_core` (code, a, b → result, zero, illegal). The top level holds only the slot register, handshake, counter and sticky flag.

## Test plan
- Reset, then ADD `a`=7, `b`=5 with `out_ready`=1 → after one edge, `out_valid`=1, `alu_result`=12, `zero`=0, `op_count`=1.
- SUB `a`=5, `b`=5 → `alu_result`=0, `zero`=1. SUB `a`=0, `b`=1 → 0xFFFFFFFF. SLT `a`=0xFFFFFFFF, `b`=1 → 1. SLT `a`=1, `b`=0xFFFFFFFF → 0.
- Backpressure: hold `out_ready`=0 with the slot FULL and present a new op → `in_ready`=0 and outputs are unchanged. Then raise `out_ready` → next op accepted the same cycle, no bubble.
- Back-to-back 4 ops with `out_ready`=1 → 4 consecutive valid results in order, `op_count`=4.
- Flush with the slot FULL and `in_valid`=1 → next cycle `out_valid`=0 and `op_count` unchanged. Then assert `rst` mid-stream → all outputs return to their reset values immediately.
- Illegal code 3'b110 accepted → `alu_result`=0, `reg_write_out`=0, `illegal_op`=1, which stays 1 after subsequent legal ops. Run the counter to 2^CNT_W−1 and accept one more → `op_count`=0.
